// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM encoding and sizing helper for the digit-serial subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n digits; at least one bit so the N == 1 case still has a counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// sub_digit: combinational DIGIT-bit ripple-borrow subtract cell
module sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] diff,
    output logic             bo
);

    // Ripple the borrow LSB to MSB through one full-subtractor per bit.
    always_comb begin
        bo   = bi;
        diff = '0;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i] = x[i] ^ y[i] ^ bo;
            bo      = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bo);
        end
    end

endmodule

// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: d = a - b - bin computed DIGIT bits per clock, with start/busy/done handshake
module digit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("digit_serial_subtractor: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, d_nxt;
    logic             br, a_msb, b_msb, bo, accept, last;
    logic [DIGIT-1:0] diff;

    assign accept = start && state != RUN;
    assign last   = state == RUN && cnt == CW'(N - 1);

    sub_digit #(.DIGIT(DIGIT)) u_cell (
        .x    (a_sr[DIGIT-1:0]),
        .y    (b_sr[DIGIT-1:0]),
        .bi   (br),
        .diff (diff),
        .bo   (bo)
    );

    // New digits enter d at the MSB end so the LSB digit ends up at the bottom after N shifts.
    if (DIGIT == WIDTH) begin : g_one
        assign d_nxt = diff;
    end else begin : g_shift
        assign d_nxt = {diff, d[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and handshake decode; DONE always leaves after one cycle so done is a pulse.
    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1)) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = start ? RUN : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Operand capture, digit-serial shifting, borrow chain and final flag registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            br   <= bo;
            d    <= d_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                bout <= bo;
                ovf  <= (a_msb != b_msb) && (d_nxt[WIDTH-1] != a_msb);
                zero <= d_nxt == '0;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb_digit_serial_subtractor: scoreboard bench over DIGIT = 2, 1 and 8 instances at WIDTH = 8
module tb_digit_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic       clk, rst_n, bin;
    logic [7:0] a, b;
    logic [2:0] st;
    logic       busy_v [3];
    logic       done_v [3];
    logic       bout_v [3];
    logic       ovf_v  [3];
    logic       zero_v [3];
    logic [7:0] d_v    [3];

    exp_t       q[$];
    logic [7:0] last_d [3];
    int         passed = 0;
    int         fails  = 0;
    int         total  = 0;

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(a), .b(b), .bin(bin),
        .busy(busy_v[0]), .done(done_v[0]), .d(d_v[0]), .bout(bout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
    );
    digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(a), .b(b), .bin(bin),
        .busy(busy_v[1]), .done(done_v[1]), .d(d_v[1]), .bout(bout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
    );
    digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(a), .b(b), .bin(bin),
        .busy(busy_v[2]), .done(done_v[2]), .d(d_v[2]), .bout(bout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bn);
        logic [8:0] f;
        exp_t       e;
        f      = {1'b0, av} - {1'b0, bv} - {8'd0, bn};
        e.d    = f[7:0];
        e.bout = f[8];
        e.ovf  = (av[7] != bv[7]) && (f[7] != av[7]);
        e.zero = f[7:0] == 8'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the instance's outputs in its done cycle.
    task automatic check_result(input int sel);
        exp_t e;
        e = q.pop_front();
        last_d[sel] = e.d;
        chk("done", {31'd0, done_v[sel]}, 32'd1);
        chk("busy_at_done", {31'd0, busy_v[sel]}, 32'd0);
        chk("d", {24'd0, d_v[sel]}, {24'd0, e.d});
        chk("bout", {31'd0, bout_v[sel]}, {31'd0, e.bout});
        chk("ovf", {31'd0, ovf_v[sel]}, {31'd0, e.ovf});
        chk("zero", {31'd0, zero_v[sel]}, {31'd0, e.zero});
    endtask

    // Issue one operation (start driven now), optionally poke start mid-RUN, wait for done.
    task automatic op(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic bn,
                      input int n, input int poke);
        int cyc, busy_n, both;
        a = av;
        b = bv;
        bin = bn;
        st[sel] = 1'b1;
        q.push_back(model(av, bv, bn));
        @(negedge clk);
        st[sel] = 1'b0;
        cyc = 1;
        busy_n = 0;
        both = 0;
        while (!done_v[sel] && cyc < 40) begin
            if (busy_v[sel]) busy_n++;
            if (busy_v[sel] && done_v[sel]) both++;
            st[sel] = (cyc == poke);
            if (cyc == poke) begin
                a = ~av;
                b = 8'h11;
                bin = ~bn;
            end
            @(negedge clk);
            cyc++;
        end
        st[sel] = 1'b0;
        chk("latency", cyc, n + 1);
        chk("busy_cycles", busy_n, n);
        chk("busy_done_excl", both, 0);
        check_result(sel);
    endtask

    // One cycle after done with no start: back in IDLE and the result held.
    task automatic idle_check(input int sel);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy_v[sel]}, 32'd0);
        chk("idle_done", {31'd0, done_v[sel]}, 32'd0);
        chk("d_hold", {24'd0, d_v[sel]}, {24'd0, last_d[sel]});
    endtask

    initial begin
        int nn[3];
        nn = '{4, 8, 1};
        rst_n = 1'b0;
        st = 3'b000;
        a = 8'h00;
        b = 8'h00;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_busy", {31'd0, busy_v[s]}, 32'd0);
            chk("rst_done", {31'd0, done_v[s]}, 32'd0);
            chk("rst_d", {24'd0, d_v[s]}, 32'd0);
            chk("rst_flags", {29'd0, bout_v[s], ovf_v[s], zero_v[s]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 8'h05, 8'h03, 1'b0, 4, 0);
        idle_check(0);
        op(0, 8'h00, 8'h01, 1'b1, 4, 0);
        idle_check(0);
        op(0, 8'h80, 8'h01, 1'b0, 4, 0);
        idle_check(0);
        op(0, 8'h7F, 8'hFF, 1'b0, 4, 0);
        idle_check(0);
        op(0, 8'h3C, 8'h3B, 1'b1, 4, 2);
        idle_check(0);

        // Back-to-back: the second op drives start in the first op's done cycle.
        op(0, 8'h20, 8'h03, 1'b0, 4, 0);
        op(0, 8'h10, 8'h01, 1'b0, 4, 0);
        idle_check(0);

        // Asynchronous reset mid-RUN.
        a = 8'hFF;
        b = 8'h00;
        bin = 1'b0;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_run_busy", {31'd0, busy_v[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("arst_d", {24'd0, d_v[0]}, 32'd0);
        chk("arst_flags", {28'd0, done_v[0], bout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy_v[0], done_v[0]}, 32'd0);
        chk("post_rst_d", {24'd0, d_v[0]}, 32'd0);

        for (int s = 1; s < 3; s++) begin
            op(s, 8'h05, 8'h03, 1'b0, nn[s], 0);
            idle_check(s);
            op(s, 8'h00, 8'h01, 1'b1, nn[s], 0);
            idle_check(s);
            op(s, 8'h80, 8'h01, 1'b0, nn[s], 0);
            op(s, 8'h7F, 8'hFF, 1'b0, nn[s], 0);
            idle_check(s);
        end

        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 10; k++) begin
                op(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   nn[s], (k % 3 == 0 && nn[s] > 2) ? 1 : 0);
                if (k % 2 == 0) idle_check(s);
            end
        end

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
